// File: rtl/qpm_pkg.sv
// rtl/qpm_pkg.sv - shared types and address helpers for the query-patch memory
//
// Purpose: Wishbone FSM state type, lane-index width function and the
//          Wishbone byte-address field extractors used by query_patch_wb_mem.
// Ports:   none (package)
package qpm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_ACK
  } wb_state_t;

  // Width of the lane field; at least one bit so a single-lane patch still
  // has a well-formed address slice.
  function automatic int lane_bits(input int lanes);
    int b;
    b = $clog2(lanes);
    return (b < 1) ? 1 : b;
  endfunction

  // Lane index: word address bits just above the byte offset.
  function automatic logic [31:0] adr_lane(input logic [31:0] adr, input int lb);
    return (adr >> 2) & ((32'd1 << lb) - 32'd1);
  endfunction

  // Patch row: the field directly above the lane index.
  function automatic logic [31:0] adr_row(input logic [31:0] adr, input int lb,
                                          input int aw);
    return (adr >> (lb + 2)) & ((32'd1 << aw) - 32'd1);
  endfunction

  // Region decode: every bit above the row field must match the base.
  function automatic logic adr_hit(input logic [31:0] adr, input logic [31:0] base,
                                   input int lb, input int aw);
    return (adr >> (aw + lb + 2)) == (base >> (aw + lb + 2));
  endfunction

endpackage

// File: rtl/qpm_lane_ram.sv
// rtl/qpm_lane_ram.sv - one lane slice of the patch memory
//
// Purpose: DEPTH x DATA_WIDTH dual-port RAM. Port a reads and optionally
//          writes (read-before-write); port b is read-only.
// Ports:   clk, rst_n       clock, async active-low reset (port-b output only)
//          en_a, we_a       port-a enable and write enable (active-high)
//          addr_a, wdata_a  port-a row and write data
//          rdata_a          port-a registered read data (old contents on write)
//          en_b, addr_b     port-b enable and row
//          rdata_b          port-b registered read data, holds when idle
module qpm_lane_ram #(
  parameter int DATA_WIDTH = 11,
  parameter int ADDR_WIDTH = 9,
  parameter int DEPTH      = 512
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en_a,
  input  logic                  we_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] wdata_a,
  output logic [DATA_WIDTH-1:0] rdata_a,
  input  logic                  en_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  output logic [DATA_WIDTH-1:0] rdata_b
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Storage and port-a data are deliberately unreset so this maps onto
  // block RAM; the top masks rdata_a until a core read has loaded it.
  always_ff @(posedge clk) begin
    if (en_a) begin
      rdata_a <= mem[addr_a];
      if (we_a) begin
        mem[addr_a] <= wdata_a;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_b <= '0;
    end else if (en_b) begin
      rdata_b <= mem[addr_b];
    end
  end

endmodule

// File: rtl/query_patch_wb_mem.sv
// rtl/query_patch_wb_mem.sv - patch memory with core ports and Wishbone lane access
//
// Purpose: DEPTH patches of PATCH_SIZE lanes. Port 0 is shared between the
//          core (wb_mode=0) and a Wishbone classic slave (wb_mode=1) that
//          reads/writes single lanes; port 1 is a free-running core read.
// Ports:   clk, rst_n                 clock, async active-low reset
//          wb_mode                    port-0 owner select
//          csb0, web0, addr0, wpatch0 core port 0 (active-low selects)
//          rpatch0                    core port-0 read data
//          csb1, addr1, rpatch1       core read port 1
//          wbs_*                      Wishbone classic slave
module query_patch_wb_mem
  import qpm_pkg::*;
#(
  parameter int          DATA_WIDTH = 11,
  parameter int          PATCH_SIZE = 5,
  parameter int          ADDR_WIDTH = 9,
  parameter int          DEPTH      = 512,
  parameter logic [31:0] WB_BASE    = 32'h3000_0000
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             wb_mode,
  input  logic                             csb0,
  input  logic                             web0,
  input  logic [ADDR_WIDTH-1:0]            addr0,
  input  logic [DATA_WIDTH*PATCH_SIZE-1:0] wpatch0,
  output logic [DATA_WIDTH*PATCH_SIZE-1:0] rpatch0,
  input  logic                             csb1,
  input  logic [ADDR_WIDTH-1:0]            addr1,
  output logic [DATA_WIDTH*PATCH_SIZE-1:0] rpatch1,
  input  logic                             wbs_stb_i,
  input  logic                             wbs_cyc_i,
  input  logic                             wbs_we_i,
  input  logic [3:0]                       wbs_sel_i,
  input  logic [31:0]                      wbs_dat_i,
  input  logic [31:0]                      wbs_adr_i,
  output logic                             wbs_ack_o,
  output logic [31:0]                      wbs_dat_o
);

  localparam int LB = lane_bits(PATCH_SIZE);
  localparam int PW = DATA_WIDTH * PATCH_SIZE;

  wb_state_t             state;
  logic [LB-1:0]         wb_lane;
  logic [ADDR_WIDTH-1:0] wb_row;
  logic                  wb_hit;
  logic                  accept;
  logic                  wb_ok;
  logic [LB-1:0]         lane_q;
  logic                  ok_q;
  logic                  core_en;
  logic                  core_rd;
  logic                  core_rd_q;
  logic [PW-1:0]         ram_q;
  logic [PW-1:0]         hold_q;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic                  unused_ok;

  assign wb_lane = LB'(adr_lane(wbs_adr_i, LB));
  assign wb_row  = ADDR_WIDTH'(adr_row(wbs_adr_i, LB, ADDR_WIDTH));
  assign wb_hit  = adr_hit(wbs_adr_i, WB_BASE, LB, ADDR_WIDTH);

  // Gating with rst_n keeps a strobe held through reset from touching memory.
  assign accept = rst_n && (state == ST_IDLE) && wbs_cyc_i && wbs_stb_i && wb_hit;
  // Out-of-range or wrong-mode accesses are still acked, just not performed.
  assign wb_ok  = wb_mode && (int'(wb_lane) < PATCH_SIZE) && (int'(wb_row) < DEPTH);

  assign core_en  = rst_n && !wb_mode && !csb0;
  assign core_rd  = core_en && web0;
  assign ram_addr = wb_mode ? wb_row : addr0;

  // Byte lanes, upper data bits and the byte offset carry no meaning here.
  assign unused_ok = ^{wbs_sel_i, wbs_dat_i, wbs_adr_i};

  for (genvar k = 0; k < PATCH_SIZE; k++) begin : g_lane
    logic wb_sel_lane;
    logic en_a;
    logic we_a;

    assign wb_sel_lane = accept && wb_ok && (wb_lane == LB'(k));
    // A Wishbone read enables every lane; only the selected one is used.
    assign en_a = core_en || (accept && wb_ok && !wbs_we_i) || wb_sel_lane;
    assign we_a = (core_en && !web0) || (wb_sel_lane && wbs_we_i);

    qpm_lane_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .DEPTH      (DEPTH)
    ) u_ram (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_a    (en_a),
      .we_a    (we_a),
      .addr_a  (ram_addr),
      .wdata_a (wb_mode ? wbs_dat_i[DATA_WIDTH-1:0] : wpatch0[k*DATA_WIDTH +: DATA_WIDTH]),
      .rdata_a (ram_q[k*DATA_WIDTH +: DATA_WIDTH]),
      .en_b    (!csb1),
      .addr_b  (addr1),
      .rdata_b (rpatch1[k*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  // Port-a read data is shared with Wishbone reads, so rpatch0 shows it only
  // in the cycle after a core read and otherwise replays its held copy.
  assign rpatch0 = core_rd_q ? ram_q : hold_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_rd_q <= 1'b0;
      hold_q    <= '0;
    end else begin
      core_rd_q <= core_rd;
      hold_q    <= rpatch0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      lane_q    <= '0;
      ok_q      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            lane_q <= wb_lane;
            ok_q   <= wb_ok;
            if (wbs_we_i) begin
              state     <= ST_ACK;
              wbs_ack_o <= 1'b1;
            end else begin
              state <= ST_RD;
            end
          end
        end
        ST_RD: begin
          wbs_dat_o <= ok_q ? 32'(ram_q[lane_q*DATA_WIDTH +: DATA_WIDTH]) : 32'd0;
          wbs_ack_o <= 1'b1;
          state     <= ST_ACK;
        end
        ST_ACK: begin
          wbs_ack_o <= 1'b0;
          state     <= ST_IDLE;
        end
        default: begin
          wbs_ack_o <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
